// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/HOLD control: loads a preset on start, decrements
// once per tick, pulses done on expiry and optionally auto-reloads the preset.
module countdown_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             pause,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] preset_q;

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      preset_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // start overrides everything in every state; a zero preset expires at once
      if (start) begin
        count    <= data;
        preset_q <= data;
        if (data == '0) begin
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (tick && count > ONE) begin
              count <= count - ONE;
            end else if (tick && count == ONE) begin
              done <= 1'b1;
              if (reload && preset_q != '0) begin
                count <= preset_q;
              end else begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (!pause) state <= RUN;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter with control FSM. It is the counting-down complement of the team's loadable up-counter. It loads a preset, decrements once per qualified tick from the frequency divider, and flags expiry with a one-cycle done pulse. It provides phase/interval timing for the controller, with optional auto-reload for periodic intervals.

Parameters:
WIDTH, 6, bit width of preset and count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tick  input  1  count enable strobe, one clk wide, from frequency divider
data  input  WIDTH  preset value, sampled only when start=1
start  input  1  load data into count and preset register, begin/restart counting
pause  input  1  level; while high, count is frozen
reload  input  1  level; auto-reload mode, sampled at expiry
count  output  WIDTH  current count (registered)
busy  output  1  high in RUN or HOLD (registered)
done  output  1  one-cycle expiry pulse (registered)
zero  output  1  combinational, count == 0

Behaviour:
- Reset (sync, highest priority): state=IDLE, count=0, preset_q=0, busy=0, done=0; zero=1. Reset mid-count aborts with no done pulse.
- Priority each clock: reset > start > pause > tick.
- done defaults to 0 every cycle unless set below; never high two consecutive cycles unless expiry repeats.
- States IDLE, RUN, HOLD (2-bit encoding, unused codes go to IDLE).
- IDLE:
  - start & data!=0 -> count<=data, preset_q<=data, RUN.
  - start & data==0 -> count<=0, preset_q<=0, done<=1, stay IDLE.
  - tick/pause ignored; count holds.
- RUN:
  - start -> restart: count<=data, preset_q<=data (data==0 rule as IDLE: done<=1, go IDLE).
  - else pause -> HOLD, count holds (a tick this cycle is lost).
  - else tick & count>1 -> count<=count-1.
  - else tick & count==1 -> done<=1. If reload=1 and preset_q!=0: count<=preset_q, stay RUN. Else count<=0, IDLE.
- HOLD:
  - start -> restart as in RUN.
  - else pause=0 -> RUN (first decrement on the next tick after returning).
  - ticks ignored.
- Latency: count changes on the clk edge where tick is sampled high. Expiry done is asserted in the cycle after that edge, coincident with count showing 0 or the reload value.
- Interval: preset N gives exactly N ticks from start to done.
- In reload mode count shows N..1 and never 0.
- busy = (state != IDLE), registered with state; falls in the same cycle done rises on non-reload expiry.
- Arithmetic: unsigned WIDTH bits, no wrap. Decrement from 0 is impossible by construction, since RUN never holds count=0.
- start and tick in same cycle: start wins; count=data, not data-1.
- Reload toggled mid-count has effect only at the expiry edge.
- data changes while counting are ignored except on start.

Test Plan:
- Reset, then start with data=5, tick every 4th clk -> count 5,4,3,2,1,0. done high exactly 1 clk when count=0. busy 1→0 in that cycle. 5 ticks total.
- data=3, reload=1, continuous ticks -> count 3,2,1,3,2,1,…; done pulses on each 1→3 transition; busy stays 1; count never 0.
- data=4, after 2 ticks raise pause for 10 clks with ticks present -> count frozen at 2. pause low -> decrements resume on next tick. done after 2 more ticks.
- data=0 start -> count=0, done pulse next cycle, busy stays 0. Separately, start with data=6 and tick in the same cycle -> count=6.
- RUN at count=3, start with data=9 -> count=9, no done. Then reset asserted at count=7 -> count=0, busy=0, no done, zero=1.
- WIDTH=6, data=63 -> counts 63 down to 0 over 63 ticks. Single done pulse, no underflow.
